// File: rtl/fixed_divider_seq.sv
// Sequential signed fixed-point divider: z = (a << FRAC_BITS) / b, restoring,
// one quotient bit per clock, with valid/ready handshakes on both sides.
// Quotients truncate toward zero; b == 0 and out-of-range results saturate.
module fixed_divider_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 14
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] z_o,
  output logic             div_by_zero_o,
  output logic             overflow_o
);

  localparam int unsigned N  = WIDTH + FRAC_BITS;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MaxNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q;
  logic [N-1:0]     dvd_q;
  logic [N-1:0]     quo_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] b_abs_q;
  logic             sign_q;
  logic             b_zero_q;
  logic             a_neg_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH+1:0] rem_shift;
  logic             rem_ge;
  logic [WIDTH:0]   rem_sub;
  logic             pos_ovf;
  logic             neg_ovf;
  logic [WIDTH-1:0] q_low;

  // Operand magnitudes, trial subtraction and range checks on the final quotient
  always_comb begin
    a_abs     = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
    b_abs     = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;
    rem_shift = {rem_q, dvd_q[N-1]};
    rem_ge    = rem_shift >= {2'b00, b_abs_q};
    rem_sub   = rem_shift[WIDTH:0] - {1'b0, b_abs_q};
    q_low     = quo_q[WIDTH-1:0];
    // Positive range tops out at 2^(W-1)-1; negative range reaches 2^(W-1)
    pos_ovf   = |quo_q[N-1:WIDTH-1];
    neg_ovf   = (|quo_q[N-1:WIDTH]) || (quo_q[WIDTH-1] && (|quo_q[WIDTH-2:0]));
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      dvd_q         <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      b_abs_q       <= '0;
      sign_q        <= 1'b0;
      b_zero_q      <= 1'b0;
      a_neg_q       <= 1'b0;
      cnt_q         <= '0;
      in_ready_o    <= 1'b1;
      out_valid_o   <= 1'b0;
      z_o           <= '0;
      div_by_zero_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            dvd_q      <= {a_abs, {FRAC_BITS{1'b0}}};
            quo_q      <= '0;
            rem_q      <= '0;
            b_abs_q    <= b_abs;
            sign_q     <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            a_neg_q    <= a_i[WIDTH-1];
            b_zero_q   <= (b_i == '0);
            cnt_q      <= CW'(N);
            in_ready_o <= 1'b0;
            state_q    <= (b_i == '0) ? StFix : StCalc;
          end
        end
        StCalc: begin
          dvd_q <= {dvd_q[N-2:0], 1'b0};
          quo_q <= {quo_q[N-2:0], rem_ge};
          rem_q <= rem_ge ? rem_sub : rem_shift[WIDTH:0];
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (b_zero_q) begin
            z_o           <= a_neg_q ? MaxNeg : MaxPos;
            div_by_zero_o <= 1'b1;
            overflow_o    <= 1'b0;
          end else if (!sign_q && pos_ovf) begin
            z_o           <= MaxPos;
            div_by_zero_o <= 1'b0;
            overflow_o    <= 1'b1;
          end else if (sign_q && neg_ovf) begin
            z_o           <= MaxNeg;
            div_by_zero_o <= 1'b0;
            overflow_o    <= 1'b1;
          end else begin
            // Negating q == 0 yields 0, so no special case for -0
            z_o           <= sign_q ? (~q_low + 1'b1) : q_low;
            div_by_zero_o <= 1'b0;
            overflow_o    <= 1'b0;
          end
          out_valid_o <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_divider_seq.sv
// Directed self-checking bench for fixed_divider_seq (Q18.14 defaults).
module tb_fixed_divider_seq;

  logic        clk;
  logic        reset_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] z_o;
  logic        div_by_zero_o;
  logic        overflow_o;

  int total;
  int bad;

  fixed_divider_seq #(
    .WIDTH    (32),
    .FRAC_BITS(14)
  ) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .z_o          (z_o),
    .div_by_zero_o(div_by_zero_o),
    .overflow_o   (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation; lat = edges after the accept edge until out_valid_o
  // is visible. Leaves the result pending unless ack is set.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ack,
                        output logic [31:0] z, output logic dz, output logic ov,
                        output int lat, output logic tmo);
    int w;
    tmo = 1'b0;
    w   = 0;
    while (!in_ready_o && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready_o) tmo = 1'b1;
    in_valid_i = 1'b1;
    a_i        = a;
    b_i        = b;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    a_i        = 32'hDEAD_BEEF;
    b_i        = 32'h0BAD_F00D;
    lat        = 0;
    while (!out_valid_o && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid_o) tmo = 1'b1;
    z  = z_o;
    dz = div_by_zero_o;
    ov = overflow_o;
    if (ack) begin
      out_ready_i = 1'b1;
      @(posedge clk); #1;
      out_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    #12;
    total += 5;
    if (in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", in_ready_o); end
    if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", out_valid_o); end
    if (z_o !== 32'h0) begin bad++; $display("FAIL rst_z got %h want 00000000", z_o); end
    if (div_by_zero_o !== 1'b0) begin bad++; $display("FAIL rst_dz got %b want 0", div_by_zero_o); end
    if (overflow_o !== 1'b0) begin bad++; $display("FAIL rst_ov got %b want 0", overflow_o); end
    @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] z; logic dz, ov, tmo; int lat;
    // 3.0 / 2.0 = 1.5, with the full normal-path latency
    run_op(32'h0000_C000, 32'h0000_8000, 1'b1, z, dz, ov, lat, tmo);
    total += 4;
    if (tmo || z !== 32'h0000_6000) begin bad++; $display("FAIL basic_3_2 got %h want 00006000", z); end
    if (dz !== 1'b0) begin bad++; $display("FAIL basic_3_2_dz got %b want 0", dz); end
    if (ov !== 1'b0) begin bad++; $display("FAIL basic_3_2_ov got %b want 0", ov); end
    if (lat != 47) begin bad++; $display("FAIL basic_latency got %0d want 47", lat); end
    // 1/3 truncated, then its negative truncated toward zero
    run_op(32'h0000_4000, 32'h0000_C000, 1'b1, z, dz, ov, lat, tmo);
    total++;
    if (tmo || z !== 32'h0000_1555) begin bad++; $display("FAIL third_pos got %h want 00001555", z); end
    run_op(32'hFFFF_C000, 32'h0000_C000, 1'b1, z, dz, ov, lat, tmo);
    total++;
    if (tmo || z !== 32'hFFFF_EAAB) begin bad++; $display("FAIL third_neg got %h want ffffeaab", z); end
    // -3.0 / -2.0 = 1.5
    run_op(32'hFFFF_4000, 32'hFFFF_8000, 1'b1, z, dz, ov, lat, tmo);
    total++;
    if (tmo || z !== 32'h0000_6000) begin bad++; $display("FAIL negneg got %h want 00006000", z); end
  endtask

  task automatic test_div_zero();
    logic [31:0] z; logic dz, ov, tmo; int lat;
    run_op(32'h0000_4000, 32'h0, 1'b1, z, dz, ov, lat, tmo);
    total += 4;
    if (tmo || z !== 32'h7FFF_FFFF) begin bad++; $display("FAIL dz_pos got %h want 7fffffff", z); end
    if (dz !== 1'b1) begin bad++; $display("FAIL dz_pos_flag got %b want 1", dz); end
    if (ov !== 1'b0) begin bad++; $display("FAIL dz_pos_ov got %b want 0", ov); end
    // Normal path is N CALC edges longer than the divide-by-zero path
    if (lat != 1) begin bad++; $display("FAIL dz_latency got %0d want 1", lat); end
    run_op(32'hFFFF_C000, 32'h0, 1'b1, z, dz, ov, lat, tmo);
    total += 2;
    if (tmo || z !== 32'h8000_0000) begin bad++; $display("FAIL dz_neg got %h want 80000000", z); end
    if (dz !== 1'b1) begin bad++; $display("FAIL dz_neg_flag got %b want 1", dz); end
  endtask

  task automatic test_overflow();
    logic [31:0] z; logic dz, ov, tmo; int lat;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, z, dz, ov, lat, tmo);
    total += 3;
    if (tmo || z !== 32'h7FFF_FFFF) begin bad++; $display("FAIL ovf_pos got %h want 7fffffff", z); end
    if (ov !== 1'b1) begin bad++; $display("FAIL ovf_pos_flag got %b want 1", ov); end
    if (dz !== 1'b0) begin bad++; $display("FAIL ovf_pos_dz got %b want 0", dz); end
    // -2^31 / 1.0 is exactly representable
    run_op(32'h8000_0000, 32'h0000_4000, 1'b1, z, dz, ov, lat, tmo);
    total += 2;
    if (tmo || z !== 32'h8000_0000) begin bad++; $display("FAIL min_exact got %h want 80000000", z); end
    if (ov !== 1'b0) begin bad++; $display("FAIL min_exact_ov got %b want 0", ov); end
    // -2^31 / -2^-14 saturates positive
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, z, dz, ov, lat, tmo);
    total += 2;
    if (tmo || z !== 32'h7FFF_FFFF) begin bad++; $display("FAIL ovf_negneg got %h want 7fffffff", z); end
    if (ov !== 1'b1) begin bad++; $display("FAIL ovf_negneg_flag got %b want 1", ov); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] z; logic dz, ov, tmo; int lat;
    int unstable;
    run_op(32'h0000_4000, 32'h0000_C000, 1'b0, z, dz, ov, lat, tmo);
    unstable = 0;
    // Hold off the consumer; stray operands must not disturb anything
    for (int i = 0; i < 10; i++) begin
      in_valid_i = 1'b1;
      a_i        = 32'h0001_0000 + i;
      b_i        = 32'h0;
      @(posedge clk); #1;
      if (out_valid_o !== 1'b1 || z_o !== 32'h0000_1555 || div_by_zero_o !== 1'b0 ||
          overflow_o !== 1'b0 || in_ready_o !== 1'b0) unstable++;
    end
    in_valid_i = 1'b0;
    total += 2;
    if (tmo || z !== 32'h0000_1555) begin bad++; $display("FAIL bp_result got %h want 00001555", z); end
    if (unstable != 0) begin bad++; $display("FAIL bp_hold got %0d unstable cycles want 0", unstable); end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    total += 2;
    if (out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_release_valid got %b want 0", out_valid_o); end
    if (in_ready_o !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b want 1", in_ready_o); end
    // -4.0 / 2.0 = -2.0
    run_op(32'hFFFF_0000, 32'h0000_8000, 1'b1, z, dz, ov, lat, tmo);
    total++;
    if (tmo || z !== 32'hFFFF_8000) begin bad++; $display("FAIL b2b_second got %h want ffff8000", z); end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] z; logic dz, ov, tmo; int lat;
    int spurious;
    in_valid_i = 1'b1;
    a_i        = 32'h7FFF_FFFF;
    b_i        = 32'h0000_0001;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset_i = 1'b1;
    #1;
    total += 5;
    if (in_ready_o !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got %b want 1", in_ready_o); end
    if (out_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b want 0", out_valid_o); end
    if (z_o !== 32'h0) begin bad++; $display("FAIL midrst_z got %h want 00000000", z_o); end
    if (div_by_zero_o !== 1'b0) begin bad++; $display("FAIL midrst_dz got %b want 0", div_by_zero_o); end
    if (overflow_o !== 1'b0) begin bad++; $display("FAIL midrst_ov got %b want 0", overflow_o); end
    @(negedge clk);
    reset_i  = 1'b0;
    spurious = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (out_valid_o !== 1'b0) spurious++;
    end
    total++;
    if (spurious != 0) begin bad++; $display("FAIL midrst_spurious got %0d want 0", spurious); end
    run_op(32'h0001_0000, 32'h0000_4000, 1'b1, z, dz, ov, lat, tmo);
    total++;
    if (tmo || z !== 32'h0001_0000) begin bad++; $display("FAIL midrst_new_op got %h want 00010000", z); end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    a_i         = '0;
    b_i         = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
